serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock using a
// single full-adder slice (two half-adder cells plus an OR of their carries)
// and a 1-bit carry flip-flop.  One addition takes WIDTH shift cycles plus a
// one-cycle DONE state, so a new operation can begin every WIDTH+2 cycles.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   rst    : synchronous, active-high reset
//   start  : request to begin an addition (honoured only in IDLE)
//   a, b   : operands, captured on the edge that accepts start
//   busy   : high while bits are being processed (SHIFT state)
//   done   : one-cycle pulse marking sum/carry as the new result
//   sum    : a+b modulo 2^WIDTH, held until the next result is ready
//   carry  : carry-out of bit WIDTH-1, held alongside sum
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // The counter must be able to hold WIDTH itself so that it never wraps
    // on the final increment of an operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry_ff;
    logic [CW-1:0]    bit_cnt;

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_sum;
    logic ha2_carry;
    logic slice_carry;

    // Full-adder slice: first half adder combines the operand LSBs, the
    // second folds in the stored carry; either half adder can produce the
    // carry-out, never both.
    assign ha1_sum     = op_a[0] ^ op_b[0];
    assign ha1_carry   = op_a[0] & op_b[0];
    assign ha2_sum     = ha1_sum ^ carry_ff;
    assign ha2_carry   = ha1_sum & carry_ff;
    assign slice_carry = ha1_carry | ha2_carry;

    // Controller and datapath in one block.  The accumulator fills from the
    // MSB end, so after WIDTH shifts bit 0 of the sum sits at acc[0].  The
    // visible sum/carry are loaded only on the edge that finishes the last
    // bit, which keeps partial shift contents off the outputs and lets the
    // previous result stay visible throughout SHIFT and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            carry_ff <= 1'b0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a     <= a;
                        op_b     <= b;
                        acc      <= '0;
                        carry_ff <= 1'b0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    acc      <= {ha2_sum, acc[WIDTH-1:1]};
                    op_a     <= {1'b0, op_a[WIDTH-1:1]};
                    op_b     <= {1'b0, op_b[WIDTH-1:1]};
                    carry_ff <= slice_carry;
                    bit_cnt  <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        sum   <= {ha2_sum, acc[WIDTH-1:1]};
                        carry <= slice_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Scoreboard bench for serial_adder (WIDTH=8).  The driver computes each
// expected result as plain a+b and the cycle its done pulse is due, and
// queues it when the start is accepted.  A separate monitor checks busy,
// done, sum and carry on every falling edge against the queue head and the
// last delivered result.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           accept_cyc;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int free_at    = 0;
    int last_accept = 0;
    logic rst_at_edge = 1'b0;
    logic armed       = 1'b0;
    logic [W-1:0] last_sum   = '0;
    logic         last_carry = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and a copy of rst as seen by the DUT at that edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = rst;
        if (rst) armed = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared = compared + 1;
        if (act !== expv) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    // Drive one cycle of inputs and apply the acceptance rule: a start is
    // taken only when the adder is idle, i.e. at least W+2 edges after the
    // previous acceptance, or one edge after a reset edge.
    task automatic applyStimulus(input logic s, input logic r, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] full;
        exp_t e;
        start = s;
        rst   = r;
        a     = x;
        b     = y;
        if (r) begin
            free_at = cyc + 2;
        end else if (s && (cyc + 1 >= free_at)) begin
            full         = {1'b0, x} + {1'b0, y};
            e.s          = full[W-1:0];
            e.c          = full[W];
            e.accept_cyc = cyc + 1;
            e.done_cyc   = cyc + 1 + W;
            exp_q.push_back(e);
            last_accept  = cyc + 1;
            free_at      = cyc + 1 + W + 2;
        end
        @(negedge clk);
    endtask

    // Wait for the adder to become free (poking start with junk operands
    // meanwhile, which must be ignored), then issue one operation.
    task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic noisy);
        int guard = 0;
        while (cyc + 1 < free_at && guard < 100) begin
            applyStimulus(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0,
                          W'($urandom), W'($urandom));
            guard++;
        end
        applyStimulus(1'b1, 1'b0, x, y);
    endtask

    // Monitor: checks every cycle once the first reset has been seen.
    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        if (armed) begin
            if (rst_at_edge) begin
                while (exp_q.size() > 0 && exp_q[0].accept_cyc <= cyc) void'(exp_q.pop_front());
                last_sum   = '0;
                last_carry = 1'b0;
            end
            exp_done = (exp_q.size() > 0) && (cyc == exp_q[0].done_cyc);
            exp_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].done_cyc - W) && (cyc < exp_q[0].done_cyc);
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                last_sum   = exp_q[0].s;
                last_carry = exp_q[0].c;
                void'(exp_q.pop_front());
            end
            checkOutput("sum", 32'(sum), 32'(last_sum));
            checkOutput("carry", 32'(carry), 32'(last_carry));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, '0, '0);
        applyStimulus(1'b0, 1'b1, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Directed values, including carry-out and no-leak cases.
        runOp(8'h5A, 8'h3C, 1'b0);
        runOp(8'hFF, 8'h01, 1'b0);
        runOp(8'h00, 8'h00, 1'b0);
        runOp(8'hFF, 8'hFF, 1'b0);

        // Start re-pulsed mid-operation with different operands.
        runOp(8'h37, 8'h42, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h01);
        applyStimulus(1'b0, 1'b0, 8'h01, 8'h01);

        // Reset on the 4th shift cycle aborts the operation silently.
        runOp(8'hC3, 8'h5D, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'hAA, 8'h55);
        applyStimulus(1'b0, 1'b0, 8'hAA, 8'h55);
        applyStimulus(1'b0, 1'b0, 8'hAA, 8'h55);
        applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55);
        for (int i = 0; i < W + 4; i++) applyStimulus(1'b0, 1'b0, '0, '0);

        // Reset and start on the same edge: reset wins, then a normal start.
        applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
        runOp(8'h80, 8'h80, 1'b0);

        // Start held high: one acceptance every W+2 cycles.
        for (int i = 0; i < 5 * (W + 2) + 2; i++) applyStimulus(1'b1, 1'b0, 8'h10, 8'h20);
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Randomized operations with ignored start pokes, gaps and resets.
        for (int n = 0; n < 150; n++) begin
            runOp(W'($urandom), W'($urandom), 1'b1);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < int'($urandom_range(0, W + 1)); k++)
                    applyStimulus(1'b0, 1'b0, W'($urandom), W'($urandom));
                applyStimulus(1'($urandom_range(0, 1)), 1'b1, W'($urandom), W'($urandom));
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                applyStimulus(1'b0, 1'b0, W'($urandom), W'($urandom));
        end

        for (int i = 0; i < W + 4; i++) applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("pending_results", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
